// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: loaded with the round-10 key, each accepted
// step produces the previous round key, ending at the original cipher key.
module inv_key_expansion (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         done
);

    // Forward AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX[{8'd255 - x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        rot_word = {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Rcon is indexed by the round being left, not the one being entered.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         valid_q, valid_d;
    logic [31:0]  n0, n1, n2, n3;

    always_comb begin
        n3 = key_q[31:0]   ^ key_q[63:32];
        n2 = key_q[63:32]  ^ key_q[95:64];
        n1 = key_q[95:64]  ^ key_q[127:96];
        n0 = key_q[127:96] ^ sub_word(rot_word(n3)) ^ {rcon(idx_q), 24'h0};

        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (start) begin
            key_d   = last_key;
            idx_d   = 4'd10;
            valid_d = 1'b1;
        end else if (next && valid_q && (idx_q != 4'd0)) begin
            key_d = {n0, n1, n2, n3};
            idx_d = idx_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= 128'h0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign key_valid = valid_q;
    assign done      = valid_q && (idx_q == 4'd0);

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: FIPS-197 vector table plus a cycle scoreboard
// driven by an independent software reverse key schedule.
module tb_inv_key_expansion;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] last_key = 128'h0;
    logic         next = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         done;

    inv_key_expansion dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key), .next(next),
        .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic         valid;
        logic         dn;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] mk;
    logic [3:0]   midx;
    logic         mvalid;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        gmul = p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = inv ^ 8'h63;
        for (int r = 1; r <= 4; r++) s = s ^ ((inv << r) | (inv >> (8 - r)));
        m_sbox = s;
    endfunction

    function automatic logic [7:0] m_rcon(input logic [3:0] i);
        logic [7:0] r = 8'h01;
        if (i < 4'd1 || i > 4'd10) return 8'h00;
        for (int k = 1; k < int'(i); k++) r = xtime(r);
        m_rcon = r;
    endfunction

    task automatic model_edge(input logic st, input logic [127:0] key, input logic nx);
        logic [31:0] w0, w1, w2, w3, t, s;
        if (st) begin
            mk = key; midx = 4'd10; mvalid = 1'b1;
        end else if (nx && mvalid && midx != 4'd0) begin
            w0 = mk[127:96]; w1 = mk[95:64]; w2 = mk[63:32]; w3 = mk[31:0];
            w3 = w3 ^ w2; w2 = w2 ^ w1; w1 = w1 ^ w0;
            t = {w3[23:0], w3[31:24]};
            s = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
            w0 = w0 ^ s ^ {m_rcon(midx), 24'h0};
            mk = {w0, w1, w2, w3};
            midx = midx - 4'd1;
        end
    endtask

    task automatic cyc(input logic st, input logic [127:0] key, input logic nx);
        exp_t e;
        @(negedge clk);
        start = st; last_key = key; next = nx;
        model_edge(st, key, nx);
        e.key = mk; e.idx = midx; e.valid = mvalid; e.dn = mvalid && (midx == 4'd0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("sb_key", round_key, e.key);
        chk("sb_idx", 128'(round_idx), 128'(e.idx));
        chk("sb_valid", 128'(key_valid), 128'(e.valid));
        chk("sb_done", 128'(done), 128'(e.dn));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_key"}, round_key, 128'h0);
        chk({tag, "_idx"}, 128'(round_idx), 128'h0);
        chk({tag, "_valid"}, 128'(key_valid), 128'h0);
        chk({tag, "_done"}, 128'(done), 128'h0);
    endtask

    typedef struct {
        logic         st;
        logic         nx;
        logic [3:0]   exp_idx;
        logic         exp_done;
        logic [127:0] exp_key;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 4'd10, 1'b0, K10};
        tbl[1]  = '{1'b0, 1'b1, 4'd9,  1'b0, 128'hac7766f3_19fadc21_28d12941_575c006e};
        tbl[2]  = '{1'b0, 1'b1, 4'd8,  1'b0, 128'head27321_b58dbad2_312bf560_7f8d292f};
        tbl[3]  = '{1'b0, 1'b1, 4'd7,  1'b0, 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f};
        tbl[4]  = '{1'b0, 1'b1, 4'd6,  1'b0, 128'h6d88a37a_110b3efd_dbf98641_ca0093fd};
        tbl[5]  = '{1'b0, 1'b1, 4'd5,  1'b0, 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc};
        tbl[6]  = '{1'b0, 1'b1, 4'd4,  1'b0, 128'hef44a541_a8525b7f_b671253b_db0bad00};
        tbl[7]  = '{1'b0, 1'b1, 4'd3,  1'b0, 128'h3d80477d_4716fe3e_1e237e44_6d7a883b};
        tbl[8]  = '{1'b0, 1'b1, 4'd2,  1'b0, 128'hf2c295f2_7a96b943_5935807a_7359f67f};
        tbl[9]  = '{1'b0, 1'b1, 4'd1,  1'b0, 128'ha0fafe17_88542cb1_23a33939_2a6c7605};
        tbl[10] = '{1'b0, 1'b1, 4'd0,  1'b1, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
        tbl[11] = '{1'b0, 1'b1, 4'd0,  1'b1, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
        tbl[12] = '{1'b0, 1'b1, 4'd0,  1'b1, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};

        mk = 128'h0; midx = 4'd0; mvalid = 1'b0;

        // Power-on reset
        #12;
        chk_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // next before any start is ignored
        cyc(1'b0, K10, 1'b1);
        chk_zero("noload");

        // Load and step once
        cyc(1'b1, K10, 1'b0);
        chk("load_idx", 128'(round_idx), 128'd10);
        chk("load_valid", 128'(key_valid), 128'd1);
        cyc(1'b0, 128'h0, 1'b1);
        chk("step1_key", round_key, 128'hac7766f3_19fadc21_28d12941_575c006e);
        chk("step1_idx", 128'(round_idx), 128'd9);
        cyc(1'b0, 128'h0, 1'b1);

        // Asynchronous reset mid-sequence, away from any clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        mk = 128'h0; midx = 4'd0; mvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, K10, 1'b1);
        chk_zero("postrst");

        // Full walk with next held, table of FIPS-197 round keys
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].st, K10, tbl[i].nx);
            chk($sformatf("walk%0d_key", i), round_key, tbl[i].exp_key);
            chk($sformatf("walk%0d_idx", i), 128'(round_idx), 128'(tbl[i].exp_idx));
            chk($sformatf("walk%0d_done", i), 128'(done), 128'(tbl[i].exp_done));
        end

        // start wins over next in the same cycle
        cyc(1'b1, K10, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 128'h0, 1'b1);
        chk("pre_prio_idx", 128'(round_idx), 128'd6);
        cyc(1'b1, K10, 1'b1);
        chk("prio_idx", 128'(round_idx), 128'd10);
        chk("prio_key", round_key, K10);

        // Reload with an all-zero key at idx 4, then walk against the model
        for (int i = 0; i < 6; i++) cyc(1'b0, 128'h0, 1'b1);
        chk("pre_reload_idx", 128'(round_idx), 128'd4);
        cyc(1'b1, 128'h0, 1'b0);
        chk("reload_key", round_key, 128'h0);
        for (int i = 0; i < 12; i++)
            cyc(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        chk("reload_done", 128'(done), 128'd1);

        // Hold with no requests keeps the final key
        cyc(1'b0, 128'h0, 1'b0);
        cyc(1'b0, 128'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inv_key_expansion.md
# inv_key_expansion

Reverse AES-128 key scheduler for the decryption datapath. It is loaded with the final (round-10) round key and walks the key schedule backwards, producing one earlier round key per `next` request. The last key produced is the original cipher key. It sits between the key store and the inverse-cipher round logic, so decryption can generate round keys on the fly instead of storing all eleven. It reuses the existing `rot_word` and `sub_word` blocks; no inverse S-box is needed.

## Interface
Parameters: none. Key length is fixed at 128 bits and the round count at 10.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — load `last_key` as round 10 (one-cycle pulse).
- `last_key`  in  128  — round-10 key. Word 0 is `[127:96]`; word 3 is `[31:0]`.
- `next`  in  1  — request the previous round key (one-cycle pulse).
- `round_key`  out  128  — current round key, registered, same word order.
- `round_idx`  out  4  — round number of `round_key`, 10 down to 0.
- `key_valid`  out  1  — `round_key` and `round_idx` are meaningful.
- `done`  out  1  — `round_idx == 0` and `key_valid`; `round_key` holds the cipher key.

## Operation
- State is the 128-bit key register `K` (words k0..k3), the 4-bit `idx` counter and the `valid` flag.
- Backward step from round i to round i-1. Inputs are the current words k0..k3 and round i. All four new words are computed combinationally from the current register in a single cycle:
  - n3 = k3 ^ k2
  - n2 = k2 ^ k1
  - n1 = k1 ^ k0
  - n0 = k0 ^ SubWord(RotWord(n3)) ^ {Rcon(i), 24'h0}
- RotWord is a left rotate by one byte: `{b0,b1,b2,b3}` becomes `{b1,b2,b3,b0}`, with b0 in `[31:24]`.
- Rcon is indexed by the **current** round i:
  - i = 1..10 gives 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Any other value gives 00. This value is unreachable in a step.
- Control, evaluated in priority order on each rising edge:
  1. `start` = 1: K ← `last_key`, idx ← 10, valid ← 1. `next` is ignored that cycle.
  2. Else if `next` = 1 and valid = 1 and idx ≠ 0: K ← {n0,n1,n2,n3} and idx ← idx − 1.
  3. Else: hold.
- `next` is ignored when valid = 0 (never loaded) or idx = 0 (done). K and idx do not change.
- `start` during a sequence aborts it and reloads immediately. No drain is needed.
- `done` is combinational from the registers: valid & (idx == 0).
- All XORs are 32 bits wide with no carries. idx never wraps below 0.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - `round_key` = 128'h0
  - `round_idx` = 0
  - `key_valid` = 0
  - `done` = 0
- Reset takes effect immediately, including mid-sequence. The next load requires `start`.
- `start` sampled high at edge n: at n+1, `round_key` = `last_key`, `round_idx` = 10, `key_valid` = 1.
- `next` sampled high at edge n with stepping allowed: `round_key` and `round_idx` update at n+1.
  - Latency is 1 cycle. Throughput is one key per cycle, so `next` may be held high continuously.
- From `start`, continuous `next` reaches `done` 11 cycles after the `start` edge.
- `done` holds until the next `start` or reset.
- The combinational path rot_word → sub_word → XOR from `K` to the next-state `K` is the critical path and must close at system clock.

## Test plan
Vectors use the FIPS-197 AES-128 key.

1. Reset, then load and step once.
   - Stimulus: assert `rst_n`=0 mid-run, release; pulse `start` with `last_key` = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; then pulse `next`.
   - During reset: all outputs 0.
   - Cycle after `start`: `round_idx`=10, `key_valid`=1.
   - Cycle after `next`: `round_key` = ac7766f3_19fadc21_28d12941_575c006e, `round_idx`=9.
2. Full walk with `next` held high for 12 cycles after `start`.
   - `round_idx`=1 shows a0fafe17_88542cb1_23a33939_2a6c7605.
   - `round_idx`=0 shows 2b7e1516_28aed2a6_abf71588_09cf4f3c with `done`=1.
   - The extra `next` pulses leave all outputs unchanged.
3. `next` before any `start` after reset: `key_valid`, `round_idx` and `round_key` all remain 0.
4. `start` and `next` asserted in the same cycle at `round_idx`=6: result is `round_idx`=10 and `round_key` = `last_key` (start has priority).
5. Reload mid-sequence: at `round_idx`=4, pulse `start` with all-zero `last_key`, then walk with `next`.
   - Each step must match the software reverse-schedule model, with the correct Rcon per round.
   - `done` rises only at idx 0.
